// File: rtl/load_store_buffer_pkg.sv
// Shared definitions for the load/store buffer slice.
// Contents: queue geometry, I/O address boundary, memory op encodings,
// memory access size codes, the control FSM state type, and small
// decode helpers used by the top and the load-extension unit.
package load_store_buffer_pkg;

    localparam int LSB_SIZE     = 8;
    localparam int LSB_SIZE_BIT = 3;
    localparam int ROB_SIZE_BIT = 3;

    // Addresses at or above this boundary are memory-mapped I/O.
    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    // Memory instruction encodings carried on inst_op.
    localparam logic [2:0] LSB_OP_LB  = 3'b000;
    localparam logic [2:0] LSB_OP_LH  = 3'b001;
    localparam logic [2:0] LSB_OP_LW  = 3'b010;
    localparam logic [2:0] LSB_OP_SB  = 3'b011;
    localparam logic [2:0] LSB_OP_LBU = 3'b100;
    localparam logic [2:0] LSB_OP_LHU = 3'b101;
    localparam logic [2:0] LSB_OP_SH  = 3'b110;
    localparam logic [2:0] LSB_OP_SW  = 3'b111;

    // Access size codes driven on mem_size.
    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_WAIT  = 2'd1,
        ST_STORE_WAIT = 2'd2,
        ST_STORE_ACK  = 2'd3
    } lsb_state_e;

    // True for SB/SH/SW.
    function automatic logic is_store(input logic [2:0] op);
        logic r;
        case (op)
            LSB_OP_SB, LSB_OP_SH, LSB_OP_SW: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

    // Access width for an op.
    function automatic logic [1:0] mem_size_of(input logic [2:0] op);
        logic [1:0] r;
        case (op)
            LSB_OP_LB, LSB_OP_LBU, LSB_OP_SB: r = MEM_SIZE_BYTE;
            LSB_OP_LH, LSB_OP_LHU, LSB_OP_SH: r = MEM_SIZE_HALF;
            LSB_OP_LW, LSB_OP_SW:             r = MEM_SIZE_WORD;
            default:                          r = MEM_SIZE_WORD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsb_load_extend.sv
// Combinational load-data extension.
// Ports:
//   op    - memory op encoding (load ops select the extension)
//   raw   - right-aligned raw data returned by memory
//   value - sign-extended (LB/LH) or zero-extended (LBU/LHU) result;
//           LW and any non-load op pass raw through unchanged.
module lsb_load_extend
    import load_store_buffer_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] raw,
    output logic [31:0] value
);

    // Select the extension based on the load width and signedness.
    always_comb begin
        value = raw;
        case (op)
            LSB_OP_LB:  value = {{24{raw[7]}}, raw[7:0]};
            LSB_OP_LH:  value = {{16{raw[15]}}, raw[15:0]};
            LSB_OP_LBU: value = {24'h00_0000, raw[7:0]};
            LSB_OP_LHU: value = {16'h0000, raw[15:0]};
            default:    value = raw;
        endcase
    end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue between issue and the memory controller.
// Entries resolve operands by snooping the ALU and LSB write-back buses.
// One access runs at a time from the head; stores and I/O loads wait
// until their ROB entry is the ROB head.
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global stall), clear (flush)
//   inst_*        - issue interface from the decoder; full back-pressure
//   alu_*         - ALU write-back snoop
//   lsb_*         - load write-back (also snooped internally), lsb_st_ok
//   rob_idx_head, rob_head_valid - ROB head information
//   mem_*         - memory controller request/response
module load_store_buffer
    import load_store_buffer_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear,
    input  logic                    inst_valid,
    input  logic [2:0]              inst_op,
    input  logic                    inst_rs1_ready,
    input  logic                    inst_rs2_ready,
    input  logic [31:0]             inst_rs1_val,
    input  logic [31:0]             inst_rs2_val,
    input  logic [ROB_SIZE_BIT-1:0] inst_rs1_rob,
    input  logic [ROB_SIZE_BIT-1:0] inst_rs2_rob,
    input  logic [31:0]             inst_imm,
    input  logic [ROB_SIZE_BIT-1:0] inst_rob_idx,
    output logic                    full,
    input  logic                    alu_valid,
    input  logic [ROB_SIZE_BIT-1:0] alu_rob_idx,
    input  logic [31:0]             alu_value,
    output logic                    lsb_valid,
    output logic [ROB_SIZE_BIT-1:0] lsb_rob_idx,
    output logic [31:0]             lsb_value,
    input  logic [ROB_SIZE_BIT-1:0] rob_idx_head,
    input  logic                    rob_head_valid,
    output logic                    lsb_st_ok,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [1:0]              mem_size,
    input  logic                    mem_done,
    input  logic [31:0]             mem_rdata
);

    localparam int PTR_W = LSB_SIZE_BIT;
    localparam int CNT_W = LSB_SIZE_BIT + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LSB_SIZE);

    // Queue storage
    logic [LSB_SIZE-1:0]     busy_r;
    logic [LSB_SIZE-1:0]     rs1_rdy_r;
    logic [LSB_SIZE-1:0]     rs2_rdy_r;
    logic [2:0]              op_r      [LSB_SIZE];
    logic [31:0]             rs1_val_r [LSB_SIZE];
    logic [31:0]             rs2_val_r [LSB_SIZE];
    logic [31:0]             imm_r     [LSB_SIZE];
    logic [ROB_SIZE_BIT-1:0] rs1_rob_r [LSB_SIZE];
    logic [ROB_SIZE_BIT-1:0] rs2_rob_r [LSB_SIZE];
    logic [ROB_SIZE_BIT-1:0] rob_r     [LSB_SIZE];

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    lsb_state_e state_r;
    logic       discard_r;

    logic                    mem_req_r;
    logic                    mem_we_r;
    logic [31:0]             mem_addr_r;
    logic [31:0]             mem_wdata_r;
    logic [1:0]              mem_size_r;
    logic                    lsb_valid_r;
    logic [ROB_SIZE_BIT-1:0] lsb_rob_idx_r;
    logic [31:0]             lsb_value_r;
    logic                    lsb_st_ok_r;

    logic                    full_s;
    logic                    issue_s;
    logic                    deq_s;
    logic                    head_busy_s;
    logic [2:0]              head_op_s;
    logic [ROB_SIZE_BIT-1:0] head_rob_s;
    logic [31:0]             head_addr_s;
    logic                    head_is_store_s;
    logic                    rob_head_match_s;
    logic                    launch_load_s;
    logic                    launch_store_s;
    logic [31:0]             ext_value_s;
    logic                    fwd1_rdy_s;
    logic [31:0]             fwd1_val_s;
    logic                    fwd2_rdy_s;
    logic [31:0]             fwd2_val_s;

    assign full_s  = (count_r == CNT_FULL);
    assign issue_s = inst_valid && !full_s && !clear;

    // A load that was flushed while in flight is not a queue dequeue:
    // the flush already emptied the queue.
    assign deq_s = mem_done && !clear &&
                   (((state_r == ST_LOAD_WAIT) && !discard_r) ||
                    (state_r == ST_STORE_WAIT));

    assign head_busy_s      = busy_r[head_r];
    assign head_op_s        = op_r[head_r];
    assign head_rob_s       = rob_r[head_r];
    assign head_addr_s      = rs1_val_r[head_r] + imm_r[head_r];
    assign head_is_store_s  = is_store(head_op_s);
    assign rob_head_match_s = rob_head_valid && (head_rob_s == rob_idx_head);

    assign launch_load_s  = head_busy_s && !head_is_store_s && rs1_rdy_r[head_r] &&
                            ((head_addr_s < IO_BASE) || rob_head_match_s);
    assign launch_store_s = head_busy_s && head_is_store_s && rs1_rdy_r[head_r] &&
                            rs2_rdy_r[head_r] && rob_head_match_s;

    lsb_load_extend u_load_extend (
        .op    (head_op_s),
        .raw   (mem_rdata),
        .value (ext_value_s)
    );

    // Issue-time operand resolution, including same-cycle bus forwarding.
    always_comb begin
        fwd1_rdy_s = 1'b0;
        fwd1_val_s = inst_rs1_val;
        fwd2_rdy_s = 1'b0;
        fwd2_val_s = inst_rs2_val;
        if (inst_rs1_ready) begin
            fwd1_rdy_s = 1'b1;
            fwd1_val_s = inst_rs1_val;
        end else if (alu_valid && (alu_rob_idx == inst_rs1_rob)) begin
            fwd1_rdy_s = 1'b1;
            fwd1_val_s = alu_value;
        end else if (lsb_valid_r && (lsb_rob_idx_r == inst_rs1_rob)) begin
            fwd1_rdy_s = 1'b1;
            fwd1_val_s = lsb_value_r;
        end else begin
            fwd1_rdy_s = 1'b0;
            fwd1_val_s = inst_rs1_val;
        end
        if (inst_rs2_ready) begin
            fwd2_rdy_s = 1'b1;
            fwd2_val_s = inst_rs2_val;
        end else if (alu_valid && (alu_rob_idx == inst_rs2_rob)) begin
            fwd2_rdy_s = 1'b1;
            fwd2_val_s = alu_value;
        end else if (lsb_valid_r && (lsb_rob_idx_r == inst_rs2_rob)) begin
            fwd2_rdy_s = 1'b1;
            fwd2_val_s = lsb_value_r;
        end else begin
            fwd2_rdy_s = 1'b0;
            fwd2_val_s = inst_rs2_val;
        end
    end

    // Entry storage: issue writes, dequeue frees, busy entries snoop buses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_r    <= {LSB_SIZE{1'b0}};
            rs1_rdy_r <= {LSB_SIZE{1'b0}};
            rs2_rdy_r <= {LSB_SIZE{1'b0}};
            for (int i = 0; i < LSB_SIZE; i++) begin
                op_r[i]      <= 3'b000;
                rs1_val_r[i] <= 32'h0000_0000;
                rs2_val_r[i] <= 32'h0000_0000;
                imm_r[i]     <= 32'h0000_0000;
                rs1_rob_r[i] <= {ROB_SIZE_BIT{1'b0}};
                rs2_rob_r[i] <= {ROB_SIZE_BIT{1'b0}};
                rob_r[i]     <= {ROB_SIZE_BIT{1'b0}};
            end
        end else if (rdy_in) begin
            for (int i = 0; i < LSB_SIZE; i++) begin
                if (clear) begin
                    busy_r[i] <= 1'b0;
                end else if (issue_s && (tail_r == PTR_W'(i))) begin
                    busy_r[i]    <= 1'b1;
                    op_r[i]      <= inst_op;
                    rs1_rdy_r[i] <= fwd1_rdy_s;
                    rs1_val_r[i] <= fwd1_val_s;
                    rs1_rob_r[i] <= inst_rs1_rob;
                    rs2_rdy_r[i] <= fwd2_rdy_s;
                    rs2_val_r[i] <= fwd2_val_s;
                    rs2_rob_r[i] <= inst_rs2_rob;
                    imm_r[i]     <= inst_imm;
                    rob_r[i]     <= inst_rob_idx;
                end else begin
                    if (deq_s && (head_r == PTR_W'(i))) begin
                        busy_r[i] <= 1'b0;
                    end
                    if (busy_r[i] && !rs1_rdy_r[i]) begin
                        if (alu_valid && (alu_rob_idx == rs1_rob_r[i])) begin
                            rs1_rdy_r[i] <= 1'b1;
                            rs1_val_r[i] <= alu_value;
                        end else if (lsb_valid_r && (lsb_rob_idx_r == rs1_rob_r[i])) begin
                            rs1_rdy_r[i] <= 1'b1;
                            rs1_val_r[i] <= lsb_value_r;
                        end
                    end
                    if (busy_r[i] && !rs2_rdy_r[i]) begin
                        if (alu_valid && (alu_rob_idx == rs2_rob_r[i])) begin
                            rs2_rdy_r[i] <= 1'b1;
                            rs2_val_r[i] <= alu_value;
                        end else if (lsb_valid_r && (lsb_rob_idx_r == rs2_rob_r[i])) begin
                            rs2_rdy_r[i] <= 1'b1;
                            rs2_val_r[i] <= lsb_value_r;
                        end
                    end
                end
            end
        end
    end

    // Head/tail pointers and occupancy count.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (rdy_in) begin
            if (clear) begin
                head_r  <= {PTR_W{1'b0}};
                tail_r  <= {PTR_W{1'b0}};
                count_r <= {CNT_W{1'b0}};
            end else begin
                if (issue_s) begin
                    tail_r <= tail_r + PTR_ONE;
                end
                if (deq_s) begin
                    head_r <= head_r + PTR_ONE;
                end
                case ({issue_s, deq_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Access FSM with registered memory and write-back outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r       <= ST_IDLE;
            discard_r     <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= 32'h0000_0000;
            mem_wdata_r   <= 32'h0000_0000;
            mem_size_r    <= 2'b00;
            lsb_valid_r   <= 1'b0;
            lsb_rob_idx_r <= {ROB_SIZE_BIT{1'b0}};
            lsb_value_r   <= 32'h0000_0000;
            lsb_st_ok_r   <= 1'b0;
        end else if (rdy_in) begin
            lsb_valid_r <= 1'b0;
            lsb_st_ok_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!clear && launch_load_s) begin
                        state_r    <= ST_LOAD_WAIT;
                        discard_r  <= 1'b0;
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= head_addr_s;
                        mem_size_r <= mem_size_of(head_op_s);
                    end else if (!clear && launch_store_s) begin
                        state_r     <= ST_STORE_WAIT;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= head_addr_s;
                        mem_wdata_r <= rs2_val_r[head_r];
                        mem_size_r  <= mem_size_of(head_op_s);
                    end else begin
                        mem_req_r <= 1'b0;
                    end
                end
                ST_LOAD_WAIT: begin
                    if (mem_done) begin
                        state_r   <= ST_IDLE;
                        discard_r <= 1'b0;
                        mem_req_r <= 1'b0;
                        // Flushed loads finish silently.
                        if (!discard_r && !clear) begin
                            lsb_valid_r   <= 1'b1;
                            lsb_rob_idx_r <= head_rob_s;
                            lsb_value_r   <= ext_value_s;
                        end
                    end else if (clear) begin
                        discard_r <= 1'b1;
                    end
                end
                ST_STORE_WAIT: begin
                    if (mem_done) begin
                        state_r     <= ST_STORE_ACK;
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        lsb_st_ok_r <= 1'b1;
                    end
                end
                ST_STORE_ACK: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    discard_r <= 1'b0;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign full        = full_s;
    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign mem_size    = mem_size_r;
    assign lsb_valid   = lsb_valid_r;
    assign lsb_rob_idx = lsb_rob_idx_r;
    assign lsb_value   = lsb_value_r;
    assign lsb_st_ok   = lsb_st_ok_r;

endmodule
